// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer and its consumers.
//   ROB_SIZE       number of ROB entries (power of two)
//   ROB_TAG_W      tag width derived from ROB_SIZE
//   rob_entry_t    per-entry state {valid, done, dest, data}
//   rob_commit_t   commit broadcast {rob_en, rob_dest, rob_tag} as seen by the producer table
package reorder_buffer_pkg;

   localparam int unsigned ROB_SIZE       = 8;
   localparam int unsigned ROB_TAG_W      = $clog2(ROB_SIZE);
   localparam int unsigned ROB_REG_ADDR_W = 5;
   localparam int unsigned ROB_DATA_W     = 32;

   typedef struct packed {
      logic                      valid;
      logic                      done;
      logic [ROB_REG_ADDR_W-1:0] dest;
      logic [ROB_DATA_W-1:0]     data;
   } rob_entry_t;

   typedef struct packed {
      logic                      rob_en;
      logic [ROB_REG_ADDR_W-1:0] rob_dest;
      logic [ROB_TAG_W-1:0]      rob_tag;
   } rob_commit_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrap-bit circular pointer used for the ROB head and tail.
//   clk  clock, rising edge
//   rst  asynchronous active-high reset (pointer -> 0)
//   clr  synchronous clear, has priority over inc
//   inc  advance by one; the natural W+1-bit rollover toggles the wrap bit
//   ptr  {wrap bit, index}
module rob_ptr #(
   parameter int unsigned W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [W:0] ptr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Allocates a tag per issued instruction,
// collects out-of-order writebacks by tag, and retires in program order.
//   clk, rst                 clock / async active-high reset
//   stall_i                  blocks issue and commit; writeback still captured
//   flush_i                  synchronous discard of all entries (highest priority)
//   issue_valid_i/rd_i       allocation request and its destination register
//   issue_ready_o/tag_o      not-full flag and tag that an accepted issue receives
//   wb_valid_i/tag_i/data_i  writeback bus
//   rN_tag_i/ready_o/data_o  operand lookups with same-cycle writeback bypass
//   commit_*_o               head retirement broadcast and regfile write data
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned TAG_W      = ROB_TAG_W,
   parameter int unsigned REG_ADDR_W = ROB_REG_ADDR_W,
   parameter int unsigned DATA_W     = ROB_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   output logic                  issue_ready_o,
   output logic [TAG_W-1:0]      issue_tag_o,
   input  logic                  wb_valid_i,
   input  logic [TAG_W-1:0]      wb_tag_i,
   input  logic [DATA_W-1:0]     wb_data_i,
   input  logic [TAG_W-1:0]      r1_tag_i,
   output logic                  r1_ready_o,
   output logic [DATA_W-1:0]     r1_data_o,
   input  logic [TAG_W-1:0]      r2_tag_i,
   output logic                  r2_ready_o,
   output logic [DATA_W-1:0]     r2_data_o,
   output logic                  commit_en_o,
   output logic [REG_ADDR_W-1:0] commit_dest_o,
   output logic [TAG_W-1:0]      commit_tag_o,
   output logic [DATA_W-1:0]     commit_data_o
);

   localparam int unsigned DEPTH = 2 ** TAG_W;

   rob_entry_t       entries [DEPTH];
   logic [TAG_W:0]   head;
   logic [TAG_W:0]   tail;
   logic [TAG_W-1:0] head_idx;
   logic [TAG_W-1:0] tail_idx;
   logic             full;
   logic             empty;
   logic             issue_acc;
   logic             wb_hit;
   rob_entry_t       head_e;
   rob_commit_t      commit_bus;

   assign head_idx = head[TAG_W-1:0];
   assign tail_idx = tail[TAG_W-1:0];
   assign full     = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
   assign empty    = (head == tail);
   assign head_e   = entries[head_idx];

   assign issue_ready_o = !full;
   assign issue_tag_o   = tail_idx;
   assign issue_acc     = issue_valid_i & !full & !stall_i & !flush_i;

   // Only valid, not-yet-done entries accept a result; an entry issued this
   // cycle is still invalid, so a writeback to it is dropped.
   assign wb_hit = wb_valid_i & entries[wb_tag_i].valid & !entries[wb_tag_i].done;

   always_comb begin
      commit_bus          = '0;
      commit_data_o       = '0;
      commit_bus.rob_en   = !empty & head_e.valid & head_e.done & !stall_i & !flush_i;
      if (head_e.valid) begin
         commit_bus.rob_dest = head_e.dest;
         commit_bus.rob_tag  = head_idx;
         commit_data_o       = head_e.data;
      end
   end

   assign commit_en_o   = commit_bus.rob_en;
   assign commit_dest_o = commit_bus.rob_dest;
   assign commit_tag_o  = commit_bus.rob_tag;

   rob_ptr #(.W(TAG_W)) u_head (
      .clk (clk),
      .rst (rst),
      .clr (flush_i),
      .inc (commit_en_o),
      .ptr (head)
   );

   rob_ptr #(.W(TAG_W)) u_tail (
      .clk (clk),
      .rst (rst),
      .clr (flush_i),
      .inc (issue_acc),
      .ptr (tail)
   );

   // Writeback, commit and issue never touch the same entry in one cycle:
   // the head is already done (wb dropped) and the tail slot is not valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
            entries[i].done  <= 1'b0;
         end
      end else begin
         if (wb_hit) begin
            entries[wb_tag_i].done <= 1'b1;
            entries[wb_tag_i].data <= wb_data_i;
         end
         if (commit_en_o) begin
            entries[head_idx].valid <= 1'b0;
            entries[head_idx].done  <= 1'b0;
         end
         if (issue_acc) begin
            entries[tail_idx].valid <= 1'b1;
            entries[tail_idx].done  <= 1'b0;
            entries[tail_idx].dest  <= issue_rd_i;
            entries[tail_idx].data  <= '0;
         end
      end
   end

   // Operand lookups: a writeback arriving this cycle is forwarded directly.
   always_comb begin
      r1_ready_o = entries[r1_tag_i].valid & entries[r1_tag_i].done;
      r1_data_o  = entries[r1_tag_i].data;
      if (wb_valid_i && (wb_tag_i == r1_tag_i) && entries[r1_tag_i].valid) begin
         r1_ready_o = 1'b1;
         r1_data_o  = wb_data_i;
      end
   end

   always_comb begin
      r2_ready_o = entries[r2_tag_i].valid & entries[r2_tag_i].done;
      r2_data_o  = entries[r2_tag_i].data;
      if (wb_valid_i && (wb_tag_i == r2_tag_i) && entries[r2_tag_i].valid) begin
         r2_ready_o = 1'b1;
         r2_data_o  = wb_data_i;
      end
   end

endmodule
